// File: rtl/miner_pkg.sv
// Shared miner-core types and sizes, used by the header loader, the hashing core and the result stage.
package miner_pkg;

    localparam int DATA_W    = 16;
    localparam int HALFWORDS = 40;
    localparam int HDR_W     = DATA_W * HALFWORDS;
    localparam int CNT_W     = $clog2(HALFWORDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PRESENT
    } ldr_state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_START = 2'b01,
        CMD_ABORT = 2'b10,
        CMD_RSVD  = 2'b11
    } host_cmd_t;

    function automatic logic is_last_slot(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(HALFWORDS - 1);
    endfunction

endpackage

// File: rtl/miner_cmd_decode.sv
// Registers the host interrupt command into single-cycle start/abort pulses and
// delays the halfword strobe by the same cycle so data stays aligned with commands.
module miner_cmd_decode
    import miner_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    interrupt_i,
    input  logic [DW-1:0] data_i,
    input  logic          data_valid_i,
    output logic          start_pulse_o,
    output logic          abort_pulse_o,
    output logic [DW-1:0] data_o,
    output logic          data_valid_o
);

    host_cmd_t     cmd_q;
    host_cmd_t     cmd_d;
    logic          start_q, start_d;
    logic          abort_q, abort_d;
    logic [DW-1:0] data_q;
    logic          dv_q;

    // A command held for several cycles still yields only one pulse.
    always_comb begin
        cmd_d   = host_cmd_t'(interrupt_i);
        start_d = (cmd_d == CMD_START) && (cmd_q != CMD_START);
        abort_d = (cmd_d == CMD_ABORT) && (cmd_q != CMD_ABORT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q   <= CMD_NONE;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            start_q <= start_d;
            abort_q <= abort_d;
            data_q  <= data_i;
            dv_q    <= data_valid_i;
        end
    end

    assign start_pulse_o = start_q;
    assign abort_pulse_o = abort_q;
    assign data_o        = data_q;
    assign data_valid_o  = dv_q;

endmodule

// File: rtl/miner_header_loader.sv
// Collects 40 host halfwords into a 640-bit block header and offers it to the
// SHA-256d core over valid/ready; host START/ABORT commands control the load.
module miner_header_loader
    import miner_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        interrupt,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic              hdr_ready,
    output logic              hdr_valid,
    output logic [HDR_W-1:0]  hdr_data,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              overrun
);

    logic              start_pulse;
    logic              abort_pulse;
    logic [DATA_W-1:0] dly_data;
    logic              dly_valid;

    miner_cmd_decode #(
        .DW(DATA_W)
    ) u_cmd_decode (
        .clk_i        (clk),
        .rst_ni       (rst),
        .interrupt_i  (interrupt),
        .data_i       (data_in),
        .data_valid_i (data_in_valid),
        .start_pulse_o(start_pulse),
        .abort_pulse_o(abort_pulse),
        .data_o       (dly_data),
        .data_valid_o (dly_valid)
    );

    ldr_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HDR_W-1:0] hdr_q, hdr_d;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;

        if (abort_pulse) begin
            // Overrun deliberately survives an abort so the host can still read it.
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        state_d   = LOAD;
                        cnt_d     = '0;
                        overrun_d = 1'b0;
                    end
                end
                LOAD: begin
                    if (start_pulse) begin
                        cnt_d = '0;
                    end else if (dly_valid) begin
                        for (int i = 0; i < HALFWORDS; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                hdr_d[HDR_W-1-DATA_W*i -: DATA_W] = dly_data;
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        if (is_last_slot(cnt_q)) begin
                            state_d = PRESENT;
                            valid_d = 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (dly_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (valid_q && hdr_ready) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            hdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
        end
    end

    assign hdr_valid = valid_q;
    assign hdr_data  = hdr_q;
    assign busy      = busy_q;
    assign word_cnt  = cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_miner_header_loader.sv
// Directed bench for the header loader: table of full loads plus hand-written corner sequences.
module tb_miner_header_loader;
    import miner_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        interrupt = 2'b00;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_in_valid = 1'b0;
    logic              hdr_ready = 1'b0;
    logic              hdr_valid;
    logic [HDR_W-1:0]  hdr_data;
    logic              busy;
    logic [CNT_W-1:0]  word_cnt;
    logic              overrun;

    miner_header_loader dut (
        .clk          (clk),
        .rst          (rst),
        .interrupt    (interrupt),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .hdr_ready    (hdr_ready),
        .hdr_valid    (hdr_valid),
        .hdr_data     (hdr_data),
        .busy         (busy),
        .word_cnt     (word_cnt),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic seen_valid = 1'b0;

    always @(posedge clk) if (hdr_valid) seen_valid = 1'b1;

    typedef struct {
        logic [15:0] base;
        logic [15:0] inc;
        logic [15:0] exp_first;
        logic [15:0] exp_mid;
        logic [15:0] exp_last;
    } load_vec_t;

    load_vec_t vecs[4];

    task automatic chk(input string nm, input logic [HDR_W-1:0] got, input logic [HDR_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] slot(input int i);
        logic [HDR_W-1:0] sh;
        sh = hdr_data >> (HDR_W - 16 * (i + 1));
        return sh[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        interrupt = c;
        step();
        interrupt = 2'b00;
    endtask

    task automatic strobes(input int n, input logic [15:0] base, input logic [15:0] inc);
        for (int i = 0; i < n; i++) begin
            data_in       = 16'(base + inc * 16'(i));
            data_in_valid = 1'b1;
            step();
        end
        data_in_valid = 1'b0;
    endtask

    logic [HDR_W-1:0] held;

    initial begin
        vecs[0] = '{16'h0000, 16'h0001, 16'h0000, 16'h0014, 16'h0027};
        vecs[1] = '{16'hA5A5, 16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        vecs[2] = '{16'h1000, 16'h0100, 16'h1000, 16'h2400, 16'h3700};
        vecs[3] = '{16'hFFF0, 16'h0001, 16'hFFF0, 16'h0004, 16'h0017};

        // Reset values
        #12;
        chk("rst_valid", hdr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", word_cnt, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", hdr_data, 0);
        rst = 1'b1;
        step();

        // Nominal loads from the table, hdr_ready held high
        hdr_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send_cmd(2'b01);
            strobes(40, vecs[v].base, vecs[v].inc);
            chk($sformatf("v%0d_pre_valid", v), hdr_valid, 0);
            chk($sformatf("v%0d_pre_cnt", v), word_cnt, 39);
            chk($sformatf("v%0d_busy", v), busy, 1);
            step();
            chk($sformatf("v%0d_valid", v), hdr_valid, 1);
            chk($sformatf("v%0d_cnt", v), word_cnt, 40);
            chk($sformatf("v%0d_first", v), slot(0), vecs[v].exp_first);
            chk($sformatf("v%0d_mid", v), slot(20), vecs[v].exp_mid);
            chk($sformatf("v%0d_last", v), slot(39), vecs[v].exp_last);
            step();
            chk($sformatf("v%0d_done_valid", v), hdr_valid, 0);
            chk($sformatf("v%0d_done_busy", v), busy, 0);
        end

        // Backpressure: header held for 20 cycles
        hdr_ready = 1'b0;
        send_cmd(2'b01);
        strobes(40, 16'h0000, 16'h0001);
        step();
        chk("bp_valid", hdr_valid, 1);
        held = hdr_data;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("bp_hold_valid%0d", c), hdr_valid, 1);
            chk($sformatf("bp_hold_data%0d", c), hdr_data, held);
        end
        hdr_ready = 1'b1;
        step();
        chk("bp_done_valid", hdr_valid, 0);
        chk("bp_done_busy", busy, 0);

        // Abort mid-load
        seen_valid = 1'b0;
        send_cmd(2'b01);
        strobes(10, 16'h0300, 16'h0001);
        send_cmd(2'b10);
        step();
        chk("abort_cnt", word_cnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", hdr_valid, 0);
        chk("abort_no_valid_seen", seen_valid, 0);
        send_cmd(2'b01);
        strobes(40, 16'hA5A5, 16'h0000);
        step();
        chk("abort_reload_valid", hdr_valid, 1);
        chk("abort_reload_data", hdr_data, {40{16'hA5A5}});
        step();

        // Restart with a same-cycle strobe of FFFF
        hdr_ready = 1'b0;
        send_cmd(2'b01);
        strobes(15, 16'h0700, 16'h0001);
        interrupt     = 2'b01;
        data_in       = 16'hFFFF;
        data_in_valid = 1'b1;
        step();
        interrupt     = 2'b00;
        data_in_valid = 1'b0;
        strobes(40, 16'h1234, 16'h0000);
        chk("restart_pre_valid", hdr_valid, 0);
        chk("restart_pre_cnt", word_cnt, 39);
        step();
        chk("restart_valid", hdr_valid, 1);
        chk("restart_data", hdr_data, {40{16'h1234}});

        // Overrun while presenting
        held = hdr_data;
        strobes(1, 16'hDEAD, 16'h0000);
        step();
        chk("ovr_flag", overrun, 1);
        chk("ovr_valid", hdr_valid, 1);
        chk("ovr_data", hdr_data, held);
        send_cmd(2'b10);
        step();
        chk("ovr_abort_valid", hdr_valid, 0);
        chk("ovr_sticky", overrun, 1);
        send_cmd(2'b01);
        step();
        chk("ovr_cleared", overrun, 0);
        chk("ovr_restart_busy", busy, 1);
        send_cmd(2'b10);
        step();

        // Asynchronous reset while presenting
        send_cmd(2'b01);
        strobes(40, 16'h0000, 16'h0001);
        step();
        strobes(1, 16'hDEAD, 16'h0000);
        step();
        chk("ar_pre_overrun", overrun, 1);
        chk("ar_pre_valid", hdr_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", hdr_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_cnt", word_cnt, 0);
        chk("ar_overrun", overrun, 0);
        chk("ar_data", hdr_data, 0);
        #3;
        rst = 1'b1;
        step();
        hdr_ready = 1'b1;
        send_cmd(2'b01);
        strobes(40, 16'h0000, 16'h0001);
        step();
        chk("ar_reload_valid", hdr_valid, 1);
        chk("ar_reload_first", slot(0), 16'h0000);
        chk("ar_reload_last", slot(39), 16'h0027);
        step();
        chk("ar_reload_done", hdr_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miner_header_loader.md
Name: miner_header_loader

Overview:
- Upstream stage of the miner core.
- Accepts the 80-byte block header from the host as 40 sequential 16-bit halfwords on the miner data bus.
- Assembles the halfwords into one 640-bit header and hands it to the SHA-256d hashing core over a valid/ready handshake.
- Owns the host "interrupt" command decoding for load start and abort.

Parameters:
- DATA_W, 16, host bus halfword width
- HALFWORDS, 40, halfwords per header (80 bytes)
- HDR_W, DATA_W*HALFWORDS (640), assembled header width
- CNT_W, $clog2(HALFWORDS+1) (6), halfword counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- interrupt  in  2  host command: 2'b00 none, 2'b01 START, 2'b10 ABORT, 2'b11 reserved (ignored)
- data_in  in  DATA_W  host halfword, sampled when data_in_valid=1
- data_in_valid  in  1  halfword strobe, one halfword per asserted cycle
- hdr_ready  in  1  hashing core can accept a header
- hdr_valid  out  1  hdr_data holds a complete header
- hdr_data  out  HDR_W  assembled header; halfword 0 in bits [HDR_W-1 -: DATA_W]
- busy  out  1  loader in LOAD or PRESENT
- word_cnt  out  CNT_W  halfwords accepted in current load
- overrun  out  1  sticky: halfword strobed while in PRESENT

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - hdr_valid, busy and overrun are 0; word_cnt is 0; hdr_data is all zeros.
  - Reset deassertion is synchronised externally.
- FSM states are IDLE, LOAD and PRESENT. All transitions are registered.
- IDLE:
  - START: go to LOAD, word_cnt←0, overrun←0.
  - data_in_valid is ignored.
- LOAD:
  - Each data_in_valid cycle writes data_in to halfword slot word_cnt, i.e. bits [HDR_W-1-DATA_W*word_cnt -: DATA_W], and increments word_cnt.
  - If the strobe is the 40th halfword (word_cnt==HALFWORDS-1): go to PRESENT; hdr_valid=1 on the next cycle; word_cnt=40.
- PRESENT:
  - hdr_valid=1. hdr_data is held stable.
  - hdr_valid & hdr_ready in the same cycle: transfer completes; go to IDLE with hdr_valid=0 the next cycle.
  - hdr_valid is never dropped without hdr_ready or ABORT.
  - data_in_valid here sets overrun; the data is discarded.
- START while in LOAD: restart. word_cnt←0, and a halfword strobed in the same cycle is discarded.
- START while in PRESENT: ignored.
- START and data_in_valid together in IDLE: the halfword is discarded.
- ABORT from any state: go to IDLE, word_cnt←0, hdr_valid←0. overrun is held until the next START.
  - ABORT in the same cycle as a handshake in PRESENT: the transfer is considered complete, and the core must tolerate it.
- hdr_data is not cleared between loads. Partially overwritten slots remain until rewritten.
- busy = (state != IDLE), registered alongside the state.
- Latency: hdr_valid rises 1 cycle after the 40th strobe. The minimum load time is 40 cycles with data_in_valid held high.
- Reset mid-operation: immediate return to reset values. The hashing core must treat hdr_valid falling without a handshake as a discard.

Decomposition:
- Shared package miner_pkg contains:
  - typedef enum logic [1:0] {IDLE, LOAD, PRESENT} ldr_state_t
  - typedef enum logic [1:0] {CMD_NONE=2'b00, CMD_START=2'b01, CMD_ABORT=2'b10, CMD_RSVD=2'b11} host_cmd_t
  - localparams DATA_W=16, HALFWORDS=40, HDR_W=640, also reused by the hashing core and the result stage.
- One sub-module, miner_cmd_decode: registers interrupt and emits single-cycle start_pulse/abort_pulse.
  - When used, it adds 1 cycle to command latency; data strobes are delayed equally to keep alignment.
  - All other logic (FSM, counter, header register) is flat in miner_header_loader.

Test Plan:
- Nominal load: START, then 40 strobes of 16'h0000..16'h0027 with hdr_ready=1.
  - hdr_valid high 1 cycle after the last strobe.
  - hdr_data[639:624]=16'h0000 and hdr_data[15:0]=16'h0027.
  - Handshake completes; IDLE next cycle; busy=0.
- Backpressure: same load with hdr_ready=0 for 20 cycles.
  - hdr_valid and hdr_data stay stable for all 20 cycles.
  - Raising hdr_ready completes the transfer in that cycle.
- Abort mid-load: START, 10 strobes, ABORT.
  - word_cnt=0, busy=0, hdr_valid never asserted.
  - A fresh 40-halfword load of 16'hA5A5 yields all-A5 hdr_data.
- Restart: START, 15 strobes, START with a strobe of 16'hFFFF in the same cycle, then 40 strobes of 16'h1234.
  - The 16'hFFFF is dropped.
  - hdr_data is all 16'h1234; hdr_valid rises after exactly 40 post-restart strobes.
- Overrun: complete a load with hdr_ready=0, then strobe 16'hDEAD.
  - overrun=1; hdr_data unchanged.
  - overrun is cleared only by the next START.
- Async reset: assert rst=0 in PRESENT, mid-cycle.
  - hdr_valid, busy, word_cnt and overrun go to 0 immediately, without waiting for a clock edge.
  - After release, a START and 40 strobes load normally.
